// File: rtl/mcu_debug_responder.sv
// MCU-side endpoint of the UART debugger command interface.
// Services pause/resume/reset and memory/register-file debug accesses.
module mcu_debug_responder #(
    parameter int MEM_LAT    = 1,
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause,
    input  logic        resume,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        rf_rd,
    input  logic        rf_wr,
    input  logic        mem_rw_byte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mcu_busy,
    output logic [31:0] rdata,
    output logic        err,
    output logic        paused,
    output logic        mcu_stall,
    output logic        mcu_reset,
    input  logic        cpu_idle,
    output logic [31:0] dbg_mem_addr,
    output logic [31:0] dbg_mem_wdata,
    output logic        dbg_mem_re,
    output logic        dbg_mem_we,
    output logic [1:0]  dbg_mem_size,
    input  logic [31:0] dbg_mem_rdata,
    output logic [4:0]  dbg_rf_addr,
    output logic [31:0] dbg_rf_wdata,
    output logic        dbg_rf_we,
    input  logic [31:0] dbg_rf_rdata
);

    typedef enum logic [3:0] {
        S_RUN, S_PAUSING, S_PAUSED, S_RESUMING, S_MEM_RD,
        S_MEM_WR, S_RF_RD, S_RF_WR, S_RESET, S_NOP
    } state_t;

    localparam logic [3:0] RST_CNT = 4'(RST_CYCLES - 1);
    localparam logic [3:0] MEM_CNT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      ret_state;
    logic [3:0]  cnt;
    logic [1:0]  lane;
    logic        byte_rd;
    logic        any_acc;
    logic [31:0] rd_sel;

    assign any_acc = mem_rd | mem_wr | rf_rd | rf_wr;

    // Byte reads return the addressed lane zero-extended; word reads pass through.
    always_comb begin
        rd_sel = dbg_mem_rdata;
        if (byte_rd)
            rd_sel = {24'h0, dbg_mem_rdata[{lane, 3'b000} +: 8]};
    end

    // Command FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_RUN;
            ret_state     <= S_RUN;
            cnt           <= 4'd0;
            lane          <= 2'd0;
            byte_rd       <= 1'b0;
            mcu_busy      <= 1'b0;
            rdata         <= 32'h0;
            err           <= 1'b0;
            paused        <= 1'b0;
            mcu_stall     <= 1'b0;
            mcu_reset     <= 1'b0;
            dbg_mem_addr  <= 32'h0;
            dbg_mem_wdata <= 32'h0;
            dbg_mem_re    <= 1'b0;
            dbg_mem_we    <= 1'b0;
            dbg_mem_size  <= 2'd0;
            dbg_rf_addr   <= 5'd0;
            dbg_rf_wdata  <= 32'h0;
            dbg_rf_we     <= 1'b0;
        end else begin
            unique case (state)
                S_RUN, S_PAUSED: begin
                    ret_state <= state;
                    if (reset) begin
                        state     <= S_RESET;
                        mcu_reset <= 1'b1;
                        cnt       <= RST_CNT;
                        mcu_busy  <= 1'b1;
                        err       <= 1'b0;
                    end else if (pause) begin
                        mcu_busy <= 1'b1;
                        err      <= 1'b0;
                        if (state == S_RUN) begin
                            state     <= S_PAUSING;
                            mcu_stall <= 1'b1;
                            // one cycle for the stall to reach the core
                            cnt       <= 4'd1;
                        end else begin
                            state <= S_NOP;
                        end
                    end else if (resume) begin
                        mcu_busy <= 1'b1;
                        err      <= 1'b0;
                        if (state == S_PAUSED) begin
                            state     <= S_RESUMING;
                            mcu_stall <= 1'b0;
                            cnt       <= 4'd1;
                        end else begin
                            state <= S_NOP;
                        end
                    end else if (any_acc) begin
                        mcu_busy <= 1'b1;
                        if (state == S_RUN) begin
                            state <= S_NOP;
                            err   <= 1'b1;
                        end else begin
                            err <= 1'b0;
                            if (mem_rd || mem_wr) begin
                                dbg_mem_addr <= mem_rw_byte ? addr
                                              : {addr[31:2], 2'b00};
                                dbg_mem_size <= mem_rw_byte ? 2'd0 : 2'd2;
                                lane         <= addr[1:0];
                                byte_rd      <= mem_rw_byte;
                            end
                            if (mem_rd) begin
                                state      <= S_MEM_RD;
                                dbg_mem_re <= 1'b1;
                                cnt        <= MEM_CNT;
                            end else if (mem_wr) begin
                                state         <= S_MEM_WR;
                                dbg_mem_we    <= 1'b1;
                                dbg_mem_wdata <= wdata;
                            end else if (rf_rd) begin
                                state       <= S_RF_RD;
                                dbg_rf_addr <= addr[4:0];
                            end else begin
                                state        <= S_RF_WR;
                                dbg_rf_addr  <= addr[4:0];
                                dbg_rf_wdata <= wdata;
                                dbg_rf_we    <= (addr[4:0] != 5'd0);
                            end
                        end
                    end
                end
                S_PAUSING: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (cpu_idle) begin
                        state    <= S_PAUSED;
                        paused   <= 1'b1;
                        mcu_busy <= 1'b0;
                    end
                end
                S_RESUMING: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= S_RUN;
                        paused   <= 1'b0;
                        mcu_busy <= 1'b0;
                    end
                end
                S_MEM_RD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata      <= rd_sel;
                        dbg_mem_re <= 1'b0;
                        state      <= S_PAUSED;
                        mcu_busy   <= 1'b0;
                    end
                end
                S_MEM_WR: begin
                    dbg_mem_we <= 1'b0;
                    state      <= S_PAUSED;
                    mcu_busy   <= 1'b0;
                end
                S_RF_RD: begin
                    rdata    <= dbg_rf_rdata;
                    state    <= S_PAUSED;
                    mcu_busy <= 1'b0;
                end
                S_RF_WR: begin
                    dbg_rf_we <= 1'b0;
                    state     <= S_PAUSED;
                    mcu_busy  <= 1'b0;
                end
                S_RESET: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mcu_reset <= 1'b0;
                        paused    <= 1'b0;
                        mcu_stall <= 1'b0;
                        state     <= S_RUN;
                        mcu_busy  <= 1'b0;
                    end
                end
                S_NOP: begin
                    state    <= ret_state;
                    mcu_busy <= 1'b0;
                end
                default: begin
                    state    <= S_RUN;
                    mcu_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_debug_responder.sv
// Directed testbench for mcu_debug_responder.
// Memory and register file are modelled here; checks run on the falling edge.
module tb_mcu_debug_responder;

    localparam int MEM_LAT    = 2;
    localparam int RST_CYCLES = 4;

    localparam logic [6:0] C_RESET  = 7'b1000000;
    localparam logic [6:0] C_PAUSE  = 7'b0100000;
    localparam logic [6:0] C_RESUME = 7'b0010000;
    localparam logic [6:0] C_MEMRD  = 7'b0001000;
    localparam logic [6:0] C_MEMWR  = 7'b0000100;
    localparam logic [6:0] C_RFRD   = 7'b0000010;
    localparam logic [6:0] C_RFWR   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause, resume, reset;
    logic        mem_rd, mem_wr, rf_rd, rf_wr;
    logic        mem_rw_byte;
    logic [31:0] addr, wdata;
    logic        mcu_busy;
    logic [31:0] rdata;
    logic        err, paused, mcu_stall, mcu_reset;
    logic        cpu_idle;
    logic [31:0] dbg_mem_addr, dbg_mem_wdata, dbg_mem_rdata;
    logic        dbg_mem_re, dbg_mem_we;
    logic [1:0]  dbg_mem_size;
    logic [4:0]  dbg_rf_addr;
    logic [31:0] dbg_rf_wdata, dbg_rf_rdata;
    logic        dbg_rf_we;

    logic [31:0] mem [0:255];
    logic [31:0] rf  [0:31];
    int re_cnt = 0, we_cnt = 0, rf_we_cnt = 0, mrst_cnt = 0;
    int n_tests = 0, n_fail = 0;
    int cyc;

    always #5 clk = ~clk;

    mcu_debug_responder #(
        .MEM_LAT(MEM_LAT),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pause(pause), .resume(resume), .reset(reset),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_rd(rf_rd), .rf_wr(rf_wr),
        .mem_rw_byte(mem_rw_byte), .addr(addr), .wdata(wdata),
        .mcu_busy(mcu_busy), .rdata(rdata), .err(err), .paused(paused),
        .mcu_stall(mcu_stall), .mcu_reset(mcu_reset), .cpu_idle(cpu_idle),
        .dbg_mem_addr(dbg_mem_addr), .dbg_mem_wdata(dbg_mem_wdata),
        .dbg_mem_re(dbg_mem_re), .dbg_mem_we(dbg_mem_we),
        .dbg_mem_size(dbg_mem_size), .dbg_mem_rdata(dbg_mem_rdata),
        .dbg_rf_addr(dbg_rf_addr), .dbg_rf_wdata(dbg_rf_wdata),
        .dbg_rf_we(dbg_rf_we), .dbg_rf_rdata(dbg_rf_rdata)
    );

    assign dbg_mem_rdata = mem[dbg_mem_addr[9:2]];
    assign dbg_rf_rdata  = rf[dbg_rf_addr];

    always @(posedge clk) begin
        if (dbg_mem_we) begin
            we_cnt <= we_cnt + 1;
            if (dbg_mem_size == 2'd2)
                mem[dbg_mem_addr[9:2]] <= dbg_mem_wdata;
            else
                mem[dbg_mem_addr[9:2]][{dbg_mem_addr[1:0], 3'b000} +: 8]
                    <= dbg_mem_wdata[7:0];
        end
        if (dbg_mem_re) re_cnt <= re_cnt + 1;
        if (dbg_rf_we) begin
            rf_we_cnt <= rf_we_cnt + 1;
            rf[dbg_rf_addr] <= dbg_rf_wdata;
        end
        if (mcu_reset) mrst_cnt <= mrst_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse a strobe for one cycle, then count busy cycles until it drops.
    task automatic issue(input logic [6:0] cmd, input logic byt,
                         input logic [31:0] a, input logic [31:0] d,
                         output int n);
        @(negedge clk);
        {reset, pause, resume, mem_rd, mem_wr, rf_rd, rf_wr} = cmd;
        mem_rw_byte = byt;
        addr = a;
        wdata = d;
        @(negedge clk);
        {reset, pause, resume, mem_rd, mem_wr, rf_rd, rf_wr} = 7'b0;
        n = 0;
        while (mcu_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"},
            {23'h0, mcu_busy, err, paused, mcu_stall, mcu_reset,
             dbg_mem_re, dbg_mem_we, dbg_mem_size, dbg_rf_we}, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_maddr"}, dbg_mem_addr, 32'h0);
        chk({tag, "_mwdata"}, dbg_mem_wdata, 32'h0);
        chk({tag, "_rf"}, {27'h0, dbg_rf_addr} | dbg_rf_wdata, 32'h0);
    endtask

    initial begin
        int r0, w0, f0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        mem[8'h40] = 32'h11223344;
        rst_n = 1'b0;
        {reset, pause, resume, mem_rd, mem_wr, rf_rd, rf_wr} = 7'b0;
        mem_rw_byte = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        cpu_idle = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // resume while running is a one-cycle no-op
        issue(C_RESUME, 1'b0, 32'h0, 32'h0, cyc);
        chk("resume_run_busy", 32'(cyc), 32'd1);
        chk("resume_run_paused", {31'h0, paused}, 32'd0);

        // pause with core already idle
        issue(C_PAUSE, 1'b0, 32'h0, 32'h0, cyc);
        chk("pause_busy", 32'(cyc), 32'd2);
        chk("pause_st", {30'h0, paused, mcu_stall}, 32'd3);

        // word write to unaligned address
        w0 = we_cnt;
        issue(C_MEMWR, 1'b0, 32'h0000_1006, 32'hDEADBEEF, cyc);
        chk("memwr_busy", 32'(cyc), 32'd1);
        chk("memwr_pulses", 32'(we_cnt - w0), 32'd1);
        chk("memwr_addr", dbg_mem_addr, 32'h0000_1004);
        chk("memwr_size", {30'h0, dbg_mem_size}, 32'd2);

        // word read back
        r0 = re_cnt;
        issue(C_MEMRD, 1'b0, 32'h0000_1006, 32'h0, cyc);
        chk("memrd_busy", 32'(cyc), 32'd2);
        chk("memrd_re", 32'(re_cnt - r0), 32'd2);
        chk("memrd_data", rdata, 32'hDEADBEEF);

        // byte read from lane 2
        issue(C_MEMRD, 1'b1, 32'h0000_0102, 32'h0, cyc);
        chk("byterd_data", rdata, 32'h0000_0022);
        chk("byterd_addr", dbg_mem_addr, 32'h0000_0102);
        chk("byterd_size", {30'h0, dbg_mem_size}, 32'd0);

        // register file write/read and x0
        f0 = rf_we_cnt;
        issue(C_RFWR, 1'b0, 32'd5, 32'hA5A5A5A5, cyc);
        chk("rfwr_busy", 32'(cyc), 32'd1);
        chk("rfwr_pulses", 32'(rf_we_cnt - f0), 32'd1);
        f0 = rf_we_cnt;
        issue(C_RFWR, 1'b0, 32'd0, 32'h12345678, cyc);
        chk("rfwr_x0", 32'(rf_we_cnt - f0), 32'd0);
        issue(C_RFRD, 1'b0, 32'd5, 32'h0, cyc);
        chk("rfrd_busy", 32'(cyc), 32'd1);
        chk("rfrd_data", rdata, 32'hA5A5A5A5);

        // pause while paused is a no-op
        issue(C_PAUSE, 1'b0, 32'h0, 32'h0, cyc);
        chk("pause_pd_busy", 32'(cyc), 32'd1);
        chk("pause_pd_paused", {31'h0, paused}, 32'd1);

        // resume
        issue(C_RESUME, 1'b0, 32'h0, 32'h0, cyc);
        chk("resume_busy", 32'(cyc), 32'd2);
        chk("resume_st", {30'h0, paused, mcu_stall}, 32'd0);

        // illegal access while running
        r0 = re_cnt;
        issue(C_MEMRD, 1'b0, 32'h0000_1004, 32'h0, cyc);
        chk("illegal_busy", 32'(cyc), 32'd1);
        chk("illegal_err", {31'h0, err}, 32'd1);
        chk("illegal_re", 32'(re_cnt - r0), 32'd0);
        chk("illegal_rdata", rdata, 32'hA5A5A5A5);

        // next accepted command clears err; pause beats resume
        issue(C_PAUSE | C_RESUME, 1'b0, 32'h0, 32'h0, cyc);
        chk("prio_busy", 32'(cyc), 32'd2);
        chk("prio_err", {31'h0, err}, 32'd0);
        chk("prio_paused", {31'h0, paused}, 32'd1);

        // reset beats pause while paused
        w0 = mrst_cnt;
        issue(C_RESET | C_PAUSE, 1'b0, 32'h0, 32'h0, cyc);
        chk("rstcmd_busy", 32'(cyc), 32'd4);
        chk("rstcmd_pulse", 32'(mrst_cnt - w0), 32'd4);
        chk("rstcmd_st", {29'h0, paused, mcu_stall, mcu_reset}, 32'd0);

        // pause with core not idle: stays busy and stalled
        cpu_idle = 1'b0;
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("pausing_st", {29'h0, mcu_busy, mcu_stall, paused}, 32'd6);

        // rst_n during pausing clears everything
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst_n = 1'b1;
        cpu_idle = 1'b1;

        // idle arriving late extends the pause
        cpu_idle = 1'b0;
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cpu_idle = 1'b1;
        @(negedge clk);
        chk("late_idle", {30'h0, mcu_busy, paused}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_debug_responder.md
# mcu_debug_responder

MCU-side endpoint of the UART debugger's controller-to-MCU command interface. It accepts the single-cycle command strobes issued by the debug controller: pause, resume, reset, memory read/write and register-file read/write. It drives the core's stall and reset lines and the debug ports of memory and the register file, and reports progress back over `mcu_busy`. It sits between the debug controller and the RISC-V MCU core, memory and register file.

## Interface
Parameters:
- `MEM_LAT`, 1: memory read latency in cycles from `dbg_mem_re` to valid `dbg_mem_rdata` (range 1..7).
- `RST_CYCLES`, 4: number of cycles `mcu_reset` is held (range 1..15).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `pause`, `resume`, `reset` in 1 each: command strobes from the controller.
- `mem_rd`, `mem_wr`, `rf_rd`, `rf_wr` in 1 each: access command strobes from the controller.
- `mem_rw_byte` in 1: 1 = byte access, 0 = word access; qualifies `mem_rd`/`mem_wr`.
- `addr` in 32: memory address, or register index in bits [4:0].
- `wdata` in 32: write data; byte writes use [7:0].
- `mcu_busy` out 1: registered; high while a command is being serviced.
- `rdata` out 32: registered read result, held until the next read.
- `err` out 1: registered; set when an access is rejected, cleared by the next accepted command.
- `paused` out 1: registered MCU-halted status.
- `mcu_stall` out 1: stalls the core at an instruction boundary.
- `mcu_reset` out 1: core reset.
- `cpu_idle` in 1: core reports it is stalled at an instruction boundary.
- `dbg_mem_addr` out 32, `dbg_mem_wdata` out 32, `dbg_mem_re` out 1, `dbg_mem_we` out 1, `dbg_mem_size` out 2: debug memory port. `dbg_mem_size` is 0 = byte, 2 = word.
- `dbg_mem_rdata` in 32: memory read data.
- `dbg_rf_addr` out 5, `dbg_rf_wdata` out 32, `dbg_rf_we` out 1: debug register-file port.
- `dbg_rf_rdata` in 32: register-file read data, combinational.

## Operation
- States: `S_RUN`, `S_PAUSING`, `S_PAUSED`, `S_RESUMING`, `S_MEM_RD`, `S_MEM_WR`, `S_RF_RD`, `S_RF_WR`, `S_RESET`, `S_NOP`.
- Strobes are sampled only when `mcu_busy`=0, in `S_RUN` or `S_PAUSED`. Strobes arriving while busy are ignored.
- Priority when several strobes are high: `reset` > `pause` > `resume` > `mem_rd` > `mem_wr` > `rf_rd` > `rf_wr`.
- Command handling:
  - **reset** (either stable state) → `S_RESET`: `mcu_reset`=1 for `RST_CYCLES` cycles, then `S_RUN` with `paused`=0 and `mcu_stall`=0.
  - **pause** in `S_RUN` → `S_PAUSING` with `mcu_stall`=1. The first cycle with `cpu_idle`=1 → `S_PAUSED`, `paused`=1.
  - **pause** in `S_PAUSED` → `S_NOP` (one busy cycle, no change).
  - **resume** in `S_PAUSED` → `S_RESUMING` with `mcu_stall`=0 for one cycle, then `S_RUN` with `paused`=0.
  - **resume** in `S_RUN` → `S_NOP`.
- Access commands (`mem_rd`, `mem_wr`, `rf_rd`, `rf_wr`):
  - Legal only in `S_PAUSED`.
  - In `S_RUN` they go to `S_NOP`: `err`=1, no port activity, `rdata` unchanged.
- Memory access:
  - Word access: `dbg_mem_addr` = {`addr`[31:2], 2'b00}.
  - Byte access: `dbg_mem_addr` = `addr`, and read data is taken from the byte lane `addr`[1:0] and zero-extended.
  - `S_MEM_RD`: `dbg_mem_re` is held for `MEM_LAT` cycles and `rdata` captures on the last of them.
  - `S_MEM_WR`: `dbg_mem_we`=1 for exactly one cycle.
- Register-file access:
  - `S_RF_RD`: one cycle; `rdata` = `dbg_rf_rdata`.
  - `S_RF_WR`: `dbg_rf_we`=1 for one cycle, except when `addr`[4:0]=0, where no write is issued (x0).
  - Both return to `S_PAUSED`.
- `S_NOP` returns to the state it came from.

## Timing
- Reset (`rst_n`=0 at an edge): state `S_RUN`. All outputs are 0: `mcu_busy`, `rdata`, `err`, `paused`, `mcu_stall`, `mcu_reset` and every `dbg_*` output. A reset mid-operation aborts it without a trailing write.
- `mcu_busy` rises on the edge that samples the strobe, so the controller sees it high on the cycle after its strobe cycle. It falls on the edge that enters `S_RUN` or `S_PAUSED`.
- Busy duration in cycles:
  - pause: 1 + number of cycles until `cpu_idle` is seen.
  - resume: 2.
  - mem read: `MEM_LAT`.
  - mem write: 1.
  - rf read/write: 1.
  - reset: `RST_CYCLES`.
  - nop: 1.
- If `cpu_idle` is already 1 when the pause is sampled, `paused` rises 2 edges after the strobe.
- `rdata` is valid no later than the cycle `mcu_busy` falls and stays stable until the next completed read.
- `dbg_*` and `mcu_reset` outputs are registered (no combinational path from the strobes). `mcu_stall` stays high through every state from `S_PAUSING` to `S_PAUSED`.

## Test plan
- **Reset:** `rst_n`=0 for 1 cycle → all outputs 0, state `S_RUN`. Then `pause` with `cpu_idle` tied 1 → `mcu_busy` high for 2 cycles, `paused`=1, `mcu_stall`=1.
- **Pause, write, read (word):** pause, then `mem_wr` with `addr`=0x0000_1006, `wdata`=0xDEADBEEF, `mem_rw_byte`=0 → one `dbg_mem_we` pulse at 0x0000_1004, size 2. Then `mem_rd` with the same address and `MEM_LAT`=2 → `mcu_busy` high for 2 cycles, `rdata`=0xDEADBEEF.
- **Byte read:** memory word 0x11223344 at 0x100; `mem_rd` with `mem_rw_byte`=1, `addr`=0x102 → `rdata`=0x00000022.
- **Register file:** `rf_wr` to x5 with 0xA5A5A5A5, then `rf_rd` x5 → `rdata`=0xA5A5A5A5. `rf_wr` to x0 → `dbg_rf_we` never asserts.
- **Illegal accesses and no-ops:** `mem_rd` while running → 1 busy cycle, `err`=1, no `dbg_mem_re`. `resume` while running → 1 busy cycle, no state change.
- **Priority and reset:** `reset` and `pause` asserted together while paused → `mcu_reset` high for `RST_CYCLES`=4 cycles, then `paused`=0, `mcu_stall`=0. Separately, `rst_n` low during `S_PAUSING` → all outputs cleared the next cycle.
